// File: rtl/i2c_line_bridge_if.sv
// Pad-side bundle of one bridged I2C wire: per-segment readback, tristate enables and owner flags.
interface i2c_line_bridge_if #(
    parameter int C_ports = 2
);
    logic [C_ports-1:0] i;
    logic [C_ports-1:0] t;
    logic [C_ports-1:0] owner;

    // master = pad/top side, slave = the bridge itself
    modport master (output i, input t, input owner);
    modport slave  (input i, output t, output owner);
endinterface

// File: rtl/i2c_line_bridge.sv
// Open-drain repeater for one I2C wire: first segment seen low owns the wire, the bridge
// pulls every other segment low until the owner lets go, then rides out pullup recovery.
module i2c_line_bridge #(
    parameter int C_ports        = 2,
    parameter int C_filter       = 2,
    parameter int C_release_hold = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    i2c_line_bridge_if.slave bus
);
    localparam int FW = $clog2(C_filter + 1);
    localparam int HW = (C_release_hold > 1) ? $clog2(C_release_hold) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWN,
        ST_RELEASE
    } state_t;

    state_t             state_reg, state_next;
    logic [C_ports-1:0] sync1_reg, sync2_reg;
    logic [C_ports-1:0] filt;
    logic [C_ports-1:0] lows, low_oh;
    logic               low_any;
    logic [HW-1:0]      hold_reg, hold_next;
    logic [C_ports-1:0] t_reg, t_next;
    logic [C_ports-1:0] owner_reg, owner_next;

    // Pad readback is asynchronous, so the synchronizer runs on every clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= '1;
            sync2_reg <= '1;
        end else begin
            sync1_reg <= bus.i;
            sync2_reg <= sync1_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < C_ports; gi++) begin : g_port
            logic          filt_bit_reg;
            logic [FW-1:0] flt_cnt_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    filt_bit_reg <= 1'b1;
                    flt_cnt_reg  <= '0;
                end else if (clk_en) begin
                    if (sync2_reg[gi] != filt_bit_reg) begin
                        if (flt_cnt_reg == FW'(C_filter - 1)) begin
                            filt_bit_reg <= sync2_reg[gi];
                            flt_cnt_reg  <= '0;
                        end else begin
                            flt_cnt_reg <= flt_cnt_reg + 1'b1;
                        end
                    end else begin
                        flt_cnt_reg <= '0;
                    end
                end
            end

            assign filt[gi] = filt_bit_reg;
        end
    endgenerate

    // Lowest-index low segment wins when several go low together.
    assign lows    = ~filt;
    assign low_oh  = lows & (~lows + 1'b1);
    assign low_any = |lows;

    always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        t_next     = t_reg;
        owner_next = owner_reg;
        case (state_reg)
            ST_OWN: begin
                // Other segments read low only because we drive them; only the owner matters.
                if ((filt & owner_reg) != '0) begin
                    state_next = ST_RELEASE;
                    hold_next  = HW'(C_release_hold - 1);
                    t_next     = '1;
                    owner_next = '0;
                end
            end
            ST_IDLE, ST_RELEASE: begin
                t_next     = '1;
                owner_next = '0;
                if (state_reg == ST_RELEASE && hold_reg != '0) begin
                    hold_next = hold_reg - 1'b1;
                end else if (low_any) begin
                    // A low surviving the hold window is a real pull (e.g. clock stretch).
                    state_next = ST_OWN;
                    t_next     = low_oh;
                    owner_next = low_oh;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                t_next     = '1;
                owner_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            hold_reg  <= '0;
            t_reg     <= '1;
            owner_reg <= '0;
        end else if (clk_en) begin
            state_reg <= state_next;
            hold_reg  <= hold_next;
            t_reg     <= t_next;
            owner_reg <= owner_next;
        end
    end

    assign bus.t     = t_reg;
    assign bus.owner = owner_reg;
endmodule
